// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: opcode, ALU, immediate-format and branch codes shared by the RV32I control/execute slice.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b1000,
        ALU_SLL   = 4'b0001,
        ALU_SRL   = 4'b0101,
        ALU_SRA   = 4'b1101,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b1010,
        ALU_PASSB = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_U = 3'b001,
        EXT_S = 3'b010,
        EXT_B = 3'b011,
        EXT_J = 3'b100
    } ext_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_EQ   = 3'b100,
        BR_NE   = 3'b101,
        BR_LT   = 3'b110,
        BR_GE   = 3'b111
    } branch_e;

    // alt selects sub/sra; callers only raise it where the encoding allows
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000: return alt ? ALU_SUB : ALU_ADD;
            3'b001: return ALU_SLL;
            3'b010: return ALU_SLT;
            3'b011: return ALU_SLTU;
            3'b100: return ALU_XOR;
            3'b101: return alt ? ALU_SRA : ALU_SRL;
            3'b110: return ALU_OR;
            3'b111: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// rv32i_alu: 32-bit RV32I ALU with less/zero flags evaluated for every operation code.
module rv32i_alu
    import rv32i_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctr,
    output logic [31:0] result,
    output logic        less,
    output logic        zero
);

    always_comb begin
        less = alu_ctr[3] ? (a < b) : ($signed(a) < $signed(b));
        zero = a == b;
        case (alu_ctr)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:   result = {31'b0, less};
            ALU_SLTU:  result = {31'b0, less};
            ALU_PASSB: result = b;
            ALU_XOR:   result = a ^ b;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_exec.sv
// rv32i_ctrl_exec: single-cycle RV32I decode, operand mux, ALU and next-PC select resolution.
// Define BRANCH_CNT_EN to build the taken conditional-branch counter; otherwise taken_cnt is 0.
module rv32i_ctrl_exec
    import rv32i_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [2:0]  ext_op,
    output logic        reg_wr,
    output logic        mem_to_reg,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [2:0]  branch,
    output logic [3:0]  alu_ctr,
    output logic [31:0] alu_result,
    output logic        less,
    output logic        zero,
    output logic        pc_a_src,
    output logic        pc_b_src,
    output logic        illegal,
    output logic        illegal_seen,
    output logic [31:0] taken_cnt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_a_src;
    logic [1:0]  alu_b_src;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        ext_op     = EXT_I;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        mem_wr     = 1'b0;
        mem_op     = 3'b000;
        branch     = BR_NONE;
        alu_ctr    = ALU_ADD;
        alu_a_src  = 1'b0;
        alu_b_src  = 2'b00;
        illegal    = 1'b0;
        case (opcode)
            OP_LUI: begin
                ext_op    = EXT_U;
                reg_wr    = 1'b1;
                alu_b_src = 2'b01;
                alu_ctr   = ALU_PASSB;
            end
            OP_AUIPC: begin
                ext_op    = EXT_U;
                reg_wr    = 1'b1;
                alu_a_src = 1'b1;
                alu_b_src = 2'b01;
            end
            OP_IMM: begin
                reg_wr    = 1'b1;
                alu_b_src = 2'b01;
                alu_ctr   = alu_from_funct3(funct3, funct3 == 3'b101 && instr[30]);
            end
            OP_OP: begin
                reg_wr  = 1'b1;
                alu_ctr = alu_from_funct3(funct3, instr[30]);
            end
            OP_JAL: begin
                ext_op    = EXT_J;
                reg_wr    = 1'b1;
                alu_a_src = 1'b1;
                alu_b_src = 2'b10;
                branch    = BR_JAL;
            end
            OP_JALR: begin
                reg_wr    = 1'b1;
                alu_a_src = 1'b1;
                alu_b_src = 2'b10;
                branch    = BR_JALR;
            end
            OP_BRANCH: begin
                ext_op  = EXT_B;
                alu_ctr = funct3[2:1] == 2'b11 ? ALU_SLTU : ALU_SLT;
                // funct3 010/011 are reserved and resolve to no branch
                branch  = funct3[2:1] == 2'b01 ? 3'b000 : {1'b1, funct3[2], funct3[0]};
            end
            OP_LOAD: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                alu_b_src  = 2'b01;
                mem_op     = funct3;
            end
            OP_STORE: begin
                ext_op    = EXT_S;
                mem_wr    = 1'b1;
                alu_b_src = 2'b01;
                mem_op    = funct3;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_a = alu_a_src ? pc : rs1_data;
    assign alu_b = alu_b_src == 2'b01 ? imm : alu_b_src == 2'b10 ? 32'd4 : rs2_data;

    rv32i_alu u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .alu_ctr (alu_ctr),
        .result  (alu_result),
        .less    (less),
        .zero    (zero)
    );

    // branch[0] inverts the condition: eq/ne, lt/ge
    always_comb begin
        pc_a_src = branch[2] ? ((branch[1] ? less : zero) ^ branch[0]) : (branch[1] | branch[0]);
        pc_b_src = branch == BR_JALR;
    end

    always_ff @(posedge clock)
        illegal_seen <= reset ? 1'b0 : (illegal_seen | illegal);

`ifdef BRANCH_CNT_EN
    always_ff @(posedge clock)
        taken_cnt <= reset ? '0 : taken_cnt + 32'(branch[2] & pc_a_src);
`else
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32i_ctrl_exec.sv
// tb_rv32i_ctrl_exec: directed plus randomized checks of rv32i_ctrl_exec against an ISA-level reference model.
module tb_rv32i_ctrl_exec;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
    logic [2:0]  ext_op, mem_op, branch;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_result, taken_cnt;
    logic        reg_wr, mem_to_reg, mem_wr, less, zero, pc_a_src, pc_b_src, illegal, illegal_seen;

    int vectors = 0;
    int errors  = 0;
    logic        seen_m = 1'b0;
    logic [31:0] cnt_m  = '0;

    rv32i_ctrl_exec dut (
        .clock(clock), .reset(reset), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .ext_op(ext_op), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .mem_wr(mem_wr),
        .mem_op(mem_op), .branch(branch), .alu_ctr(alu_ctr), .alu_result(alu_result),
        .less(less), .zero(zero), .pc_a_src(pc_a_src), .pc_b_src(pc_b_src),
        .illegal(illegal), .illegal_seen(illegal_seen), .taken_cnt(taken_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  ext;
        logic        rw, m2r, mw;
        logic [2:0]  mop, br;
        logic [3:0]  ctr;
        logic        ill;
        logic [31:0] res;
        logic        ls, z, pa, pb;
    } exp_t;

    // RV32I register/immediate arithmetic: returns {alu code, result}
    function automatic logic [35:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0: return alt ? {4'h8, x - y} : {4'h0, x + y};
            3'd1: return {4'h1, x << y[4:0]};
            3'd2: return {4'h2, 32'($signed(x) < $signed(y))};
            3'd3: return {4'hA, 32'(x < y)};
            3'd4: return {4'h4, x ^ y};
            3'd5: return alt ? {4'hD, 32'($signed(x) >>> y[4:0])} : {4'h5, x >> y[4:0]};
            3'd6: return {4'h6, x | y};
            default: return {4'h7, x & y};
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        exp_t e;
        logic [2:0]  f3 = i[14:12];
        logic [31:0] a = r1, b = r2;
        logic        lt;
        e = '0;
        case (i[6:0])
            7'b0110111: begin e.ext = 3'd1; e.rw = 1; e.ctr = 4'h3; b = im; e.res = im; end
            7'b0010111: begin e.ext = 3'd1; e.rw = 1; a = p; b = im; e.res = p + im; end
            7'b0010011: begin e.rw = 1; b = im; {e.ctr, e.res} = arith(f3, f3 == 3'd5 && i[30], r1, im); end
            7'b0110011: begin e.rw = 1; {e.ctr, e.res} = arith(f3, i[30], r1, r2); end
            7'b1101111: begin e.ext = 3'd4; e.rw = 1; a = p; b = 4; e.res = p + 4; e.br = 3'd1; e.pa = 1; end
            7'b1100111: begin e.rw = 1; a = p; b = 4; e.res = p + 4; e.br = 3'd2; e.pa = 1; e.pb = 1; end
            7'b1100011: begin
                e.ext = 3'd3;
                e.ctr = f3[2:1] == 2'b11 ? 4'hA : 4'h2;
                lt = f3[2:1] == 2'b11 ? (r1 < r2) : ($signed(r1) < $signed(r2));
                e.res = 32'(lt);
                case (f3)
                    3'd0: begin e.br = 3'd4; e.pa = r1 == r2; end
                    3'd1: begin e.br = 3'd5; e.pa = r1 != r2; end
                    3'd4: begin e.br = 3'd6; e.pa = $signed(r1) < $signed(r2); end
                    3'd5: begin e.br = 3'd7; e.pa = $signed(r1) >= $signed(r2); end
                    3'd6: begin e.br = 3'd6; e.pa = r1 < r2; end
                    3'd7: begin e.br = 3'd7; e.pa = r1 >= r2; end
                    default: ;
                endcase
            end
            7'b0000011: begin e.rw = 1; e.m2r = 1; b = im; e.res = r1 + im; e.mop = f3; end
            7'b0100011: begin e.ext = 3'd2; e.mw = 1; b = im; e.res = r1 + im; e.mop = f3; end
            default: begin e.ill = 1; e.res = r1 + r2; end
        endcase
        e.ls = e.ctr[3] ? (a < b) : ($signed(a) < $signed(b));
        e.z  = a == b;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive on negedge, check combinational outputs, then registered outputs after the edge
    task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic rst);
        exp_t e;
        @(negedge clock);
        instr = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im; reset = rst;
        #1;
        e = model(i, p, r1, r2, im);
        check("ctrl", 32'({ext_op, reg_wr, mem_to_reg, mem_wr, mem_op, branch, alu_ctr, illegal}),
                      32'({e.ext, e.rw, e.m2r, e.mw, e.mop, e.br, e.ctr, e.ill}));
        check("alu_result", alu_result, e.res);
        check("flags", 32'({less, zero, pc_a_src, pc_b_src}), 32'({e.ls, e.z, e.pa, e.pb}));
        seen_m = rst ? 1'b0 : (seen_m | e.ill);
`ifdef BRANCH_CNT_EN
        cnt_m = rst ? '0 : cnt_m + 32'(e.br[2] & e.pa);
`endif
        @(posedge clock);
        #1;
        check("illegal_seen", 32'(illegal_seen), 32'(seen_m));
        check("taken_cnt", taken_cnt, cnt_m);
    endtask

    localparam logic [31:0] BEQ = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};

    initial begin
        logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
        logic [31:0] ri, r1, r2;
        logic [6:0]  op;

        step(32'h00B50533, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1);
        check("reset_seen", 32'(illegal_seen), 32'h0);
        step(32'h00B50533, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0);
        check("add_res", alu_result, 32'h80000000);
        check("add_ctr", 32'({reg_wr, alu_ctr}), 32'h10);

        step({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'h0, 32'h80000000, 32'h0, 32'h404, 1'b0);
        check("srai_res", alu_result, 32'hF8000000);
        check("srai_ctr", 32'(alu_ctr), 32'hD);

        step({7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        check("bltu", 32'({less, branch, pc_a_src}), 32'({1'b0, 3'b110, 1'b0}));
        step({7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011}, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        check("blt", 32'({less, branch, pc_a_src}), 32'({1'b1, 3'b110, 1'b1}));

        step({12'd8, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h100, 32'h2000, 32'h0, 32'h8, 1'b0);
        check("jalr_res", alu_result, 32'h104);
        check("jalr_sel", 32'({pc_a_src, pc_b_src, ext_op}), 32'({1'b1, 1'b1, 3'b000}));

        step(32'hFFFFFFFF, 32'h0, 32'h5, 32'h6, 32'h7, 1'b0);
        check("illegal_ctrl", 32'({illegal, ext_op, reg_wr, mem_to_reg, mem_wr, mem_op, branch, alu_ctr}), 32'h10000);
        check("illegal_sticky", 32'(illegal_seen), 32'h1);
        step(32'h00B50533, 32'h0, 32'h1, 32'h2, 32'h0, 1'b0);
        check("illegal_hold", 32'(illegal_seen), 32'h1);
        step(32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h0, 1'b1);
        check("reset_wins", 32'(illegal_seen), 32'h0);

        step(BEQ, 32'h0, 32'h33, 32'h33, 32'h0, 1'b1);
        step(BEQ, 32'h0, 32'h33, 32'h33, 32'h0, 1'b0);
        step(BEQ, 32'h0, 32'hAA, 32'hAA, 32'h0, 1'b0);
        step(BEQ, 32'h0, 32'h33, 32'h34, 32'h0, 1'b0);
        step(BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef BRANCH_CNT_EN
        check("beq_count", taken_cnt, 32'd3);
`else
        check("beq_count", taken_cnt, 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            ri = $urandom;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0 && op inside {ops}) op = 7'b0001011;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            step({ri[31:7], op}, $urandom, r1, r2, $urandom, $urandom_range(0, 31) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
